// File: rtl/fir_out_capture_pkg.sv
// Shared types, default widths and helpers for the FIR output capture block.
package fir_out_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } capture_state_t;

    localparam int DEF_DATA_INTE_WL = 4;
    localparam int DEF_DATA_FRAC_WL = 8;
    localparam int DEF_DEPTH        = 256;

    // Sign-extends the low 'width' bits of value to 64 bits; the caller truncates to the accumulator width.
    function automatic logic [63:0] sign_extend(input logic [63:0] value, input int unsigned width);
        logic [63:0] shifted;
        shifted = value << (32'd64 - width);
        return 64'($signed(shifted) >>> (32'd64 - width));
    endfunction

endpackage

// File: rtl/fir_out_capture_ram.sv
// Simple dual-port capture memory: one write port, one registered read port with a zero-force input.
module fir_out_capture_ram #(
    parameter int DATA_WL = 12,
    parameter int DEPTH   = 256,
    parameter int ADDR_WL = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [ADDR_WL-1:0] wr_addr,
    input  logic [DATA_WL-1:0] wr_data,
    input  logic               re,
    input  logic               rd_zero,
    input  logic [ADDR_WL-1:0] rd_addr,
    output logic [DATA_WL-1:0] rd_data
);

    logic [DATA_WL-1:0] mem_r [DEPTH];
    logic [DATA_WL-1:0] rd_data_r;

    // Write port; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read; out-of-range reads return zero, idle cycles hold the last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= {DATA_WL{1'b0}};
        end else if (re) begin
            rd_data_r <= rd_zero ? {DATA_WL{1'b0}} : mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/fir_out_capture.sv
// Captures one valid-qualified FIR output burst into memory for host readback.
// Optional min/max/sum statistics are built when FIR_OUT_CAPTURE_STATS_EN is defined.
module fir_out_capture
    import fir_out_capture_pkg::*;
#(
    parameter int DATA_INTE_WL = DEF_DATA_INTE_WL,
    parameter int DATA_FRAC_WL = DEF_DATA_FRAC_WL,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_WL      = $clog2(DEPTH)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          arm,
    input  logic                                          in_valid,
    input  logic signed [DATA_INTE_WL-1:-DATA_FRAC_WL]    data_in,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          overflow,
    output logic [ADDR_WL:0]                              count,
    input  logic                                          rd_en,
    input  logic [ADDR_WL-1:0]                            rd_addr,
    output logic                                          rd_valid,
    output logic signed [DATA_INTE_WL-1:-DATA_FRAC_WL]    rd_data,
    output logic signed [DATA_INTE_WL-1:-DATA_FRAC_WL]    stat_min,
    output logic signed [DATA_INTE_WL-1:-DATA_FRAC_WL]    stat_max,
    output logic signed [DATA_INTE_WL+ADDR_WL:-DATA_FRAC_WL] stat_sum
);

    localparam int unsigned SAMPLE_W = DATA_INTE_WL + DATA_FRAC_WL;
    localparam int unsigned SUM_W    = DATA_INTE_WL + ADDR_WL + DATA_FRAC_WL + 1;
    localparam logic [ADDR_WL:0] FULL_COUNT = (ADDR_WL + 1)'(DEPTH);
    localparam logic [ADDR_WL:0] ONE_COUNT  = {{ADDR_WL{1'b0}}, 1'b1};

    capture_state_t   state_r;
    capture_state_t   state_s;
    logic [ADDR_WL:0] count_r;
    logic             overflow_r;
    logic             busy_r;
    logic             done_r;
    logic             rd_valid_r;
    logic             clear_s;
    logic             store_s;
    logic             drop_s;
    logic             rd_take_s;
    logic             rd_zero_s;

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s   = state_r;
        clear_s   = 1'b0;
        store_s   = 1'b0;
        drop_s    = 1'b0;
        rd_take_s = 1'b0;
        rd_zero_s = ({1'b0, rd_addr} >= count_r);
        case (state_r)
            IDLE: begin
                if (arm) begin
                    state_s = ARMED;
                    clear_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ARMED: begin
                if (in_valid) begin
                    state_s = CAPTURE;
                    store_s = 1'b1;
                end else begin
                    state_s = ARMED;
                end
            end
            CAPTURE: begin
                if (!in_valid) begin
                    state_s = DONE;
                end else if (count_r == FULL_COUNT) begin
                    drop_s = 1'b1;
                end else begin
                    store_s = 1'b1;
                end
            end
            DONE: begin
                rd_take_s = rd_en;
                if (arm) begin
                    state_s = ARMED;
                    clear_s = 1'b1;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            count_r    <= {(ADDR_WL + 1){1'b0}};
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s == ARMED) || (state_s == CAPTURE);
            done_r     <= (state_s == DONE);
            rd_valid_r <= rd_take_s;
            if (clear_s) begin
                count_r    <= {(ADDR_WL + 1){1'b0}};
                overflow_r <= 1'b0;
            end else begin
                if (store_s) begin
                    count_r <= count_r + ONE_COUNT;
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    fir_out_capture_ram #(
        .DATA_WL (SAMPLE_W),
        .DEPTH   (DEPTH),
        .ADDR_WL (ADDR_WL)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (store_s),
        .wr_addr (count_r[ADDR_WL-1:0]),
        .wr_data (data_in),
        .re      (rd_take_s),
        .rd_zero (rd_zero_s),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

`ifdef FIR_OUT_CAPTURE_STATS_EN
    logic signed [SAMPLE_W-1:0] sample_s;
    logic signed [SAMPLE_W-1:0] min_r;
    logic signed [SAMPLE_W-1:0] max_r;
    logic signed [SUM_W-1:0]    sum_r;

    assign sample_s = data_in;

    // Running statistics over stored samples only; the first stored sample seeds min and max.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_r <= {SAMPLE_W{1'b0}};
            max_r <= {SAMPLE_W{1'b0}};
            sum_r <= {SUM_W{1'b0}};
        end else if (clear_s) begin
            min_r <= {SAMPLE_W{1'b0}};
            max_r <= {SAMPLE_W{1'b0}};
            sum_r <= {SUM_W{1'b0}};
        end else if (store_s) begin
            if ((count_r == {(ADDR_WL + 1){1'b0}}) || (sample_s < min_r)) begin
                min_r <= sample_s;
            end
            if ((count_r == {(ADDR_WL + 1){1'b0}}) || (sample_s > max_r)) begin
                max_r <= sample_s;
            end
            sum_r <= sum_r + SUM_W'(sign_extend(64'($unsigned(sample_s)), SAMPLE_W));
        end
    end

    assign stat_min = min_r;
    assign stat_max = max_r;
    assign stat_sum = sum_r;
`else
    assign stat_min = {SAMPLE_W{1'b0}};
    assign stat_max = {SAMPLE_W{1'b0}};
    assign stat_sum = {SUM_W{1'b0}};
`endif

    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign count    = count_r;
    assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_fir_out_capture.sv
// Scoreboard bench for fir_out_capture built with DEPTH=16; read results are queued at request time.
module tb_fir_out_capture;

    localparam int IW    = 4;
    localparam int FW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic                         clk;
    logic                         rst;
    logic                         arm;
    logic                         in_valid;
    logic signed [IW-1:-FW]       data_in;
    logic                         busy;
    logic                         done;
    logic                         overflow;
    logic [AW:0]                  count;
    logic                         rd_en;
    logic [AW-1:0]                rd_addr;
    logic                         rd_valid;
    logic signed [IW-1:-FW]       rd_data;
    logic signed [IW-1:-FW]       stat_min;
    logic signed [IW-1:-FW]       stat_max;
    logic signed [IW+AW:-FW]      stat_sum;

    int checks = 0;
    int errors = 0;

    logic signed [11:0] exp_q[$];
    logic signed [11:0] model_mem [DEPTH];
    int                 model_n;
    logic signed [11:0] prev_rd;

    fir_out_capture #(
        .DATA_INTE_WL (IW),
        .DATA_FRAC_WL (FW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .arm      (arm),
        .in_valid (in_valid),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .count    (count),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .stat_min (stat_min),
        .stat_max (stat_max),
        .stat_sum (stat_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Read monitor: every rd_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_unexpected", 1, 0);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
        model_n = 0;
    endtask

    task automatic put(input int v, input bit stored);
        in_valid = 1'b1;
        data_in  = 12'(v);
        if (stored && model_n < DEPTH) begin
            model_mem[model_n] = 12'(v);
            model_n++;
        end
        step();
    endtask

    task automatic idle_valid();
        in_valid = 1'b0;
        step();
    endtask

    task automatic read_one(input int a);
        rd_en   = 1'b1;
        rd_addr = 4'(a);
        exp_q.push_back((a < model_n) ? model_mem[a] : 12'sd0);
        step();
    endtask

    task automatic read_end(input string tag);
        rd_en = 1'b0;
        step();
        step();
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; arm = 1'b0; in_valid = 1'b0; data_in = 12'sd0;
        rd_en = 1'b0; rd_addr = 4'd0; model_n = 0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_stat_sum", stat_sum, 0);
        rst = 1'b1;
        step();

        // IDLE ignores valid
        put(9, 1'b0); put(9, 1'b0); idle_valid();
        chk("idle_busy", busy, 0);
        chk("idle_count", count, 0);

        // Burst 1..15
        do_arm();
        chk("armed_busy", busy, 1);
        for (int i = 1; i <= 15; i++) put(i, 1'b1);
        idle_valid();
        chk("b15_done", done, 1);
        chk("b15_busy", busy, 0);
        chk("b15_count", count, 15);
        chk("b15_ovf", overflow, 0);
        for (int a = 0; a < 16; a++) read_one(a);
        read_end("b15_reads_drained");

        // Overflow: 20 samples into DEPTH 16
        do_arm();
        chk("rearm_done", done, 0);
        chk("rearm_count", count, 0);
        for (int i = 1; i <= 20; i++) put(100 + i, 1'b1);
        idle_valid();
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        for (int a = 0; a < 16; a++) read_one(a);
        read_end("ovf_reads_drained");

        // Gap ends the burst
        do_arm();
        chk("gap_ovf_cleared", overflow, 0);
        put(5, 1'b1); put(6, 1'b1);
        idle_valid();
        chk("gap_done", done, 1);
        put(7, 1'b0); put(8, 1'b0);
        idle_valid();
        chk("gap_count", count, 2);
        read_one(2); read_one(3); read_one(0); read_one(1);
        read_end("gap_reads_drained");
        prev_rd = 12'sd6;

        // Arm while valid is already high: sample on arm cycle is not stored
        in_valid = 1'b1; data_in = 12'sd30; arm = 1'b1;
        step();
        arm = 1'b0; model_n = 0;
        rd_en = 1'b1; rd_addr = 4'd0;
        put(31, 1'b1);
        rd_en = 1'b0;
        chk("nondone_rd_valid", rd_valid, 0);
        chk("nondone_rd_data", rd_data, prev_rd);
        put(32, 1'b1); put(33, 1'b1);
        idle_valid();
        chk("midarm_count", count, 3);
        for (int a = 0; a < 4; a++) read_one(a);
        read_end("midarm_reads_drained");

        // Reset during capture
        do_arm();
        for (int i = 0; i < 10; i++) put(50 + i, 1'b1);
        in_valid = 1'b1;
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count, 0);
        chk("midrst_done", done, 0);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        do_arm();
        put(40, 1'b1); put(41, 1'b1); put(42, 1'b1);
        idle_valid();
        chk("postrst_count", count, 3);
        for (int a = 0; a < 3; a++) read_one(a);
        read_end("postrst_reads_drained");

        // Statistics
        do_arm();
        chk("stat_sum_cleared", stat_sum, 0);
        put(-2048, 1'b1); put(100, 1'b1); put(2047, 1'b1);
        idle_valid();
`ifdef FIR_OUT_CAPTURE_STATS_EN
        chk("stat_min", stat_min, -2048);
        chk("stat_max", stat_max, 2047);
        chk("stat_sum", stat_sum, 99);
`else
        chk("stat_min", stat_min, 0);
        chk("stat_max", stat_max, 0);
        chk("stat_sum", stat_sum, 0);
`endif
        for (int a = 0; a < 3; a++) read_one(a);
        read_end("stat_reads_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
